// File: rtl/tb_uart_rx_monitor.sv
`timescale 1ns/1ps
// N-channel UART receive monitor: per-channel 2-FF synchroniser, frame FSM with
// parity/framing checks, show-ahead byte FIFO and sticky error flags.
module tb_uart_rx_monitor #(
   parameter int unsigned N_CH         = 2,
   parameter int unsigned CLKS_PER_BIT = 54,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY_MODE  = 0,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic                                 ref_clk_i,
   input  logic                                 rstn_i,
   input  logic [N_CH-1:0]                      rx_i,
   input  logic [N_CH-1:0]                      pop_i,
   input  logic [N_CH-1:0]                      clr_err_i,
   output logic [N_CH*8-1:0]                    rx_data_o,
   output logic [N_CH-1:0]                      rx_valid_o,
   output logic [N_CH*$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o,
   output logic [N_CH-1:0]                      eol_o,
   output logic [N_CH-1:0]                      frame_err_o,
   output logic [N_CH-1:0]                      parity_err_o,
   output logic [N_CH-1:0]                      overflow_o
);
   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W = $clog2(DATA_BITS);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
   localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
   } state_e;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic                 sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
      state_e               state_q, state_d;
      logic [CNT_W-1:0]     cnt_q, cnt_d;
      logic [BIT_W-1:0]     bit_q, bit_d;
      logic [DATA_BITS-1:0] shreg_q, shreg_d;
      logic                 par_fail_q, par_fail_d;
      logic                 push_q, push_d;
      logic [7:0]           push_data_q, push_data_d;
      logic [7:0]           mem_q [FIFO_DEPTH];
      logic [7:0]           mem_d [FIFO_DEPTH];
      logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
      logic [CW-1:0]        count_q, count_d;
      logic                 eol_q, eol_d;
      logic                 ferr_q, ferr_d, perr_q, perr_d, ovf_q, ovf_d;
      logic                 rx_s, fall, tick, set_ferr, set_perr;
      logic                 do_pop, do_push, full;

      assign rx_s = sync2_q;
      assign fall = prev_q & ~sync2_q;
      assign tick = (cnt_q == '0);

      always_comb begin
         sync1_d     = rx_i[c];
         sync2_d     = sync1_q;
         prev_d      = sync2_q;
         state_d     = state_q;
         cnt_d       = cnt_q;
         bit_d       = bit_q;
         shreg_d     = shreg_q;
         par_fail_d  = par_fail_q;
         push_d      = 1'b0;
         push_data_d = push_data_q;
         set_ferr    = 1'b0;
         set_perr    = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (fall) begin
                  state_d = ST_START;
                  cnt_d   = HALF_BIT;
               end
            end
            ST_START: begin
               if (!tick) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else if (!rx_s) begin
                  state_d    = ST_DATA;
                  cnt_d      = FULL_BIT;
                  bit_d      = '0;
                  par_fail_d = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_DATA: begin
               if (!tick) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                  cnt_d   = FULL_BIT;
                  if (bit_q == LAST_BIT) begin
                     state_d = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_d = bit_q + BIT_W'(1);
                  end
               end
            end
            ST_PARITY: begin
               if (!tick) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  // expected bit: data XOR for even, inverted for odd
                  par_fail_d = rx_s != ((^shreg_q) ^ (PARITY_MODE == 2));
                  cnt_d      = FULL_BIT;
                  state_d    = ST_STOP;
               end
            end
            ST_STOP: begin
               if (!tick) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else if (rx_s) begin
                  state_d = ST_IDLE;
                  if (par_fail_q) begin
                     set_perr = 1'b1;
                  end else begin
                     push_d      = 1'b1;
                     push_data_d = 8'(shreg_q);
                  end
               end else begin
                  set_ferr = 1'b1;
                  state_d  = ST_BREAK;
               end
            end
            ST_BREAK: begin
               if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      always_comb begin
         full     = (count_q == DEPTH_C);
         do_pop   = pop_i[c] && (count_q != '0);
         do_push  = push_q && (!full || do_pop);
         mem_d    = mem_q;
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
         count_d  = count_q;
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (do_push && !do_pop) count_d = count_q + CW'(1);
         else if (do_pop && !do_push) count_d = count_q - CW'(1);
         eol_d  = do_push && (push_data_q == 8'h0A);
         ferr_d = (ferr_q && !clr_err_i[c]) || set_ferr;
         perr_d = (perr_q && !clr_err_i[c]) || set_perr;
         ovf_d  = (ovf_q && !clr_err_i[c]) || (push_q && full && !do_pop);
      end

      always_ff @(posedge ref_clk_i) begin
         if (!rstn_i) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            par_fail_q  <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            eol_q       <= 1'b0;
            ferr_q      <= 1'b0;
            perr_q      <= 1'b0;
            ovf_q       <= 1'b0;
         end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            par_fail_q  <= par_fail_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            eol_q       <= eol_d;
            ferr_q      <= ferr_d;
            perr_q      <= perr_d;
            ovf_q       <= ovf_d;
         end
      end

      // storage needs no reset: the data output is gated by occupancy
      always_ff @(posedge ref_clk_i) begin
         mem_q <= mem_d;
      end

      assign rx_valid_o[c]          = (count_q != '0);
      assign rx_data_o[8*c +: 8]    = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
      assign fifo_count_o[CW*c +: CW] = count_q;
      assign eol_o[c]               = eol_q;
      assign frame_err_o[c]         = ferr_q;
      assign parity_err_o[c]        = perr_q;
      assign overflow_o[c]          = ovf_q;
   end

endmodule

// File: tb/tb_tb_uart_rx_monitor.sv
`timescale 1ns/1ps
// Directed bench for tb_uart_rx_monitor: one 8N1 instance and one 8O1 instance,
// 16 clocks per bit, 4-deep FIFOs.
module tb_tb_uart_rx_monitor;
   localparam int unsigned N_CH  = 2;
   localparam int unsigned CPB   = 16;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rstn;
   logic [N_CH-1:0]      rx, pop, clr;
   logic [N_CH*8-1:0]    rx_data;
   logic [N_CH-1:0]      rx_valid, eol, frame_err, parity_err, overflow;
   logic [N_CH*CW-1:0]   fifo_count;
   logic [N_CH-1:0]      rx_p, pop_p, clr_p;
   logic [N_CH*8-1:0]    rx_data_p;
   logic [N_CH-1:0]      rx_valid_p, eol_p, frame_err_p, parity_err_p, overflow_p;
   logic [N_CH*CW-1:0]   fifo_count_p;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   tb_uart_rx_monitor #(
      .N_CH(N_CH), .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .FIFO_DEPTH(DEPTH)
   ) dut (
      .ref_clk_i(clk), .rstn_i(rstn), .rx_i(rx), .pop_i(pop), .clr_err_i(clr),
      .rx_data_o(rx_data), .rx_valid_o(rx_valid), .fifo_count_o(fifo_count),
      .eol_o(eol), .frame_err_o(frame_err), .parity_err_o(parity_err), .overflow_o(overflow)
   );

   tb_uart_rx_monitor #(
      .N_CH(N_CH), .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .FIFO_DEPTH(DEPTH)
   ) dut_par (
      .ref_clk_i(clk), .rstn_i(rstn), .rx_i(rx_p), .pop_i(pop_p), .clr_err_i(clr_p),
      .rx_data_o(rx_data_p), .rx_valid_o(rx_valid_p), .fifo_count_o(fifo_count_p),
      .eol_o(eol_p), .frame_err_o(frame_err_p), .parity_err_o(parity_err_p),
      .overflow_o(overflow_p)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_line(input bit par_dut, input int ch, input logic v);
      if (par_dut) rx_p[ch] = v;
      else rx[ch] = v;
   endtask

   task automatic hold_bit(input bit par_dut, input int ch, input logic v);
      set_line(par_dut, ch, v);
      idle(CPB);
   endtask

   task automatic send_frame(input bit par_dut, input int ch, input logic [7:0] b,
                             input bit has_par, input logic par, input logic stop);
      hold_bit(par_dut, ch, 1'b0);
      for (int i = 0; i < 8; i++) hold_bit(par_dut, ch, b[i]);
      if (has_par) hold_bit(par_dut, ch, par);
      hold_bit(par_dut, ch, stop);
      set_line(par_dut, ch, 1'b1);
   endtask

   task automatic pop_one(input int ch);
      pop[ch] = 1'b1;
      idle(1);
      pop[ch] = 1'b0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0;
      rx = '1; pop = '0; clr = '0;
      rx_p = '1; pop_p = '0; clr_p = '0;
      idle(4);
      rstn = 1'b1;
      idle(2);
      check_eq("rst_valid", rx_valid, 0);
      check_eq("rst_count", fifo_count, 0);
      check_eq("rst_data", rx_data, 0);
      check_eq("rst_flags", {eol, frame_err, parity_err, overflow}, 0);

      // 1: 0x55 on ch0, latency from start-bit drive to rx_valid
      fork
         send_frame(0, 0, 8'h55, 0, 1'b0, 1'b1);
         begin
            int n;
            n = 0;
            while (!rx_valid[0] && n < 400) begin
               @(posedge clk);
               n++;
               #1;
            end
            check_eq("t1_latency", n, 157);
         end
      join
      idle(2);
      check_eq("t1_data", rx_data[7:0], 8'h55);
      check_eq("t1_count", fifo_count[CW-1:0], 1);
      check_eq("t1_ch1_idle", {rx_valid[1], fifo_count[2*CW-1:CW]}, 0);
      pop_one(0);
      check_eq("t1_after_pop", {rx_valid[0], fifo_count[CW-1:0]}, 0);

      // 2: overflow on ch1
      for (int b = 1; b <= 5; b++) begin
         send_frame(0, 1, 8'(b), 0, 1'b0, 1'b1);
         idle(2);
      end
      idle(2);
      check_eq("t2_count", fifo_count[2*CW-1:CW], 4);
      check_eq("t2_overflow", overflow, 2'b10);
      for (int b = 1; b <= 4; b++) begin
         check_eq("t2_pop_data", rx_data[15:8], 8'(b));
         pop_one(1);
      end
      check_eq("t2_drained", {rx_valid[1], fifo_count[2*CW-1:CW]}, 0);
      clr[1] = 1'b1;
      idle(1);
      clr[1] = 1'b0;
      check_eq("t2_ovf_cleared", overflow, 0);

      // 3: framing error then long break
      send_frame(0, 0, 8'h3F, 0, 1'b0, 1'b0);
      check_eq("t3_frame_err", frame_err, 2'b01);
      rx[0] = 1'b0;
      idle(40 * CPB);
      check_eq("t3_no_push", {rx_valid[0], fifo_count[CW-1:0]}, 0);
      rx[0] = 1'b1;
      idle(2 * CPB);
      send_frame(0, 0, 8'hA5, 0, 1'b0, 1'b1);
      idle(4);
      check_eq("t3_recovered", {rx_valid[0], rx_data[7:0]}, {1'b1, 8'hA5});
      pop_one(0);
      clr[0] = 1'b1;
      idle(1);
      clr[0] = 1'b0;
      check_eq("t3_ferr_cleared", frame_err, 0);

      // 4: short glitch on ch0, then 0x0A on ch1
      rx[0] = 1'b0;
      idle(4);
      rx[0] = 1'b1;
      idle(40);
      check_eq("t4_glitch", {rx_valid[0], fifo_count[CW-1:0], frame_err, parity_err}, 0);
      fork
         begin
            send_frame(0, 1, 8'h0A, 0, 1'b0, 1'b1);
            idle(20);
         end
         begin
            int e;
            e = 0;
            repeat (200) begin
               @(posedge clk);
               #1;
               if (eol[1]) e++;
            end
            check_eq("t4_eol_pulses", e, 1);
         end
      join
      check_eq("t4_data", rx_data[15:8], 8'h0A);
      check_eq("t4_eol_ch0", eol[0], 0);
      pop_one(1);

      // 5: odd parity instance
      send_frame(1, 0, 8'h07, 1, 1'b1, 1'b1);
      idle(4);
      check_eq("t5_parity_err", parity_err_p, 2'b01);
      check_eq("t5_no_push", fifo_count_p[CW-1:0], 0);
      send_frame(1, 0, 8'h07, 1, 1'b0, 1'b1);
      idle(4);
      check_eq("t5_accept", {fifo_count_p[CW-1:0], rx_data_p[7:0]}, {3'd1, 8'h07});
      check_eq("t5_sticky", {parity_err_p, frame_err_p}, 4'b0100);

      // 6: reset in the middle of a ch0 frame
      send_frame(0, 1, 8'h11, 0, 1'b0, 1'b1);
      idle(4);
      check_eq("t6_pre_count", fifo_count[2*CW-1:CW], 1);
      fork
         send_frame(0, 0, 8'hFF, 0, 1'b0, 1'b1);
         begin
            idle(60);
            rstn = 1'b0;
            idle(1);
            check_eq("t6_rst_outputs",
                     {rx_data, rx_valid, fifo_count, eol, frame_err, parity_err, overflow}, 0);
            rstn = 1'b1;
         end
      join
      idle(16);
      send_frame(0, 0, 8'h3C, 0, 1'b0, 1'b1);
      idle(4);
      check_eq("t6_clean", {fifo_count[CW-1:0], rx_data[7:0]}, {3'd1, 8'h3C});
      for (int b = 8'h41; b <= 8'h43; b++) begin
         send_frame(0, 0, 8'(b), 0, 1'b0, 1'b1);
         idle(2);
      end
      check_eq("t6_full", fifo_count[CW-1:0], 4);
      fork
         send_frame(0, 0, 8'h44, 0, 1'b0, 1'b1);
         begin
            idle(156);
            pop[0] = 1'b1;
            idle(1);
            pop[0] = 1'b0;
            check_eq("t6_pushpop_count", fifo_count[CW-1:0], 4);
            check_eq("t6_pushpop_ovf", overflow, 0);
         end
      join
      for (int b = 8'h41; b <= 8'h44; b++) begin
         check_eq("t6_drain", rx_data[7:0], 8'(b));
         pop_one(0);
      end
      check_eq("t6_empty", rx_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
